// File: rtl/vmsu_8bit_div.sv
// Sequential restoring divider, the inverse of the vmsu_8bit datapath.
// A 2N-bit dividend is divided by an N-bit divisor to give an N-bit quotient
// and an N-bit remainder, unsigned or two's complement as chosen by control.
// One quotient bit is produced per clock. Done follows the accepting edge by
// exactly 2N+1 clocks, including the divide-by-zero case.
module vmsu_8bit_div #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  input  logic           control,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0]  LAST_IT = CW'(2*N-1);
  localparam logic [2*N-1:0] UMAX    = (2*N)'((1 << N) - 1);
  localparam logic [2*N-1:0] SPMAX   = (2*N)'((1 << (N-1)) - 1);
  localparam logic [2*N-1:0] SNMAX   = (2*N)'(1 << (N-1));

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;

  // Captured operand signs and magnitudes plus the iteration state.
  logic           sa;
  logic           sb;
  logic           sgn;
  logic [2*N-1:0] dvd_m;
  logic [N-1:0]   dvs_m;
  logic [N-1:0]   dvd_lo;
  logic [N:0]     prem;
  logic [2*N-1:0] qm;

  // Per-iteration and final-correction combinational values.
  logic [N:0]     shifted;
  logic           ge;
  logic [N:0]     diff;
  logic           neg;
  logic [2*N-1:0] q_res;
  logic [N-1:0]   r_res;
  logic           div_zero;
  logic [N-1:0]   q_fix;
  logic [N-1:0]   r_fix;
  logic           ovf_fix;

  // Conditional two's-complement negation, dividend/quotient width.
  function automatic logic [2*N-1:0] cneg_w(input logic [2*N-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Conditional two's-complement negation, divisor/remainder width.
  function automatic logic [N-1:0] cneg_n(input logic [N-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Range check of the quotient magnitude against the N-bit result format.
  // A negative signed result may reach one step further than a positive one.
  function automatic logic quot_ovf(input logic [2*N-1:0] q, input logic s, input logic n);
    if (!s)
      return q > UMAX;
    else if (!n)
      return q > SPMAX;
    else
      return q > SNMAX;
  endfunction

  // Restoring step: bring in the next dividend bit and trial-subtract.
  // prem never exceeds the divisor magnitude, so its low N bits hold the
  // whole partial remainder before the shift.
  always_comb begin
    shifted = {prem[N-1:0], dvd_m[2*N-1]};
    ge      = shifted >= {1'b0, dvs_m};
    diff    = shifted - {1'b0, dvs_m};
  end

  // Sign correction, overflow detection and the divide-by-zero override.
  always_comb begin
    neg      = sa ^ sb;
    q_res    = cneg_w(qm, neg);
    r_res    = cneg_n(prem[N-1:0], sa);
    div_zero = (dvs_m == '0);
    q_fix    = q_res[N-1:0];
    r_fix    = r_res;
    ovf_fix  = quot_ovf(qm, sgn, neg);
    if (div_zero) begin
      q_fix   = '1;
      r_fix   = dvd_lo;
      ovf_fix = 1'b1;
    end
  end

  // Datapath: capture magnitudes on the accepting edge, then iterate in RUN.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sgn    <= control;
      sa     <= control & dividend[2*N-1];
      sb     <= control & divisor[N-1];
      dvd_m  <= cneg_w(dividend, control & dividend[2*N-1]);
      dvs_m  <= cneg_n(divisor, control & divisor[N-1]);
      dvd_lo <= dividend[N-1:0];
      prem   <= '0;
      qm     <= '0;
    end else if (state == RUN) begin
      dvd_m <= {dvd_m[2*N-2:0], 1'b0};
      if (ge) begin
        prem <= diff;
        qm   <= {qm[2*N-2:0], 1'b1};
      end else begin
        prem <= shifted;
        qm   <= {qm[2*N-2:0], 1'b0};
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_IT)
            state <= FIX;
        end
        FIX: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_fix;
          dz        <= div_zero;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
